// File: rtl/mux_arb_pkg.sv
// Shared types and the round-robin pick helper for the four-way mux arbiter.
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Returns {found, index}: the first requester at or after ptr (mod 4) not masked by excl.
    function automatic logic [SEL_W:0] rr_pick(
        input logic [N_REQ-1:0] req_v,
        input logic [SEL_W-1:0] ptr,
        input logic [N_REQ-1:0] excl
    );
        logic [SEL_W:0]   res;
        logic [SEL_W-1:0] idx;
        res = {1'b0, {SEL_W{1'b0}}};
        for (int k = 0; k < N_REQ; k++) begin
            idx = ptr + SEL_W'(k);
            if (!res[SEL_W] && req_v[idx] && !excl[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    function automatic logic [N_REQ-1:0] idx2oh(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh = {N_REQ{1'b0}};
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux4_dp.sv
// DW-wide 4:1 data mux used as the shared datapath of the arbiter.
module mux4_dp #(
    parameter int DW = 1
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    input  logic [DW-1:0] d,
    input  logic [1:0]    sel,
    output logic [DW-1:0] y
);

    // Lane select.
    always_comb begin
        y = {DW{1'b0}};
        case (sel)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            2'd3:    y = d;
            default: y = {DW{1'b0}};
        endcase
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter granting one of four requesters ownership of a shared 4:1 mux.
// Optional per-owner grant timeout enabled by defining MUX_ARB_TIMEOUT_EN.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DW       = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    req,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    input  logic [DW-1:0] d,
    output logic [3:0]    gnt,
    output logic [1:0]    sel,
    output logic          busy,
    output logic [DW-1:0] out
);

    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("mux_rr_arbiter: MAX_HOLD must be >= 1");
    end

    arb_state_e       state_r, state_nxt_s;
    logic [N_REQ-1:0] gnt_r, gnt_nxt_s;
    logic [SEL_W-1:0] sel_r, sel_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic [SEL_W-1:0] ptr_r, ptr_nxt_s;
    logic [SEL_W-1:0] rot_ptr_s;
    logic [SEL_W:0]   idle_pick_s, rel_pick_s;
    logic             force_s, release_s;
    logic [DW-1:0]    y_s;

    // On release the search restarts just past the outgoing owner, which never competes.
    assign rot_ptr_s   = sel_r + 2'd1;
    assign idle_pick_s = rr_pick(req, ptr_r, 4'b0000);
    assign rel_pick_s  = rr_pick(req, rot_ptr_s, gnt_r);
    assign release_s   = (state_r == GRANT) && (!req[sel_r] || force_s);

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_cnt_r, hold_nxt_s;

    assign force_s = (hold_cnt_r == HOLD_MAX) && rel_pick_s[SEL_W];

    // Hold counter: counts cycles of the current owner, saturates for a sole requester.
    always_comb begin
        hold_nxt_s = {HOLD_W{1'b0}};
        if ((state_r == GRANT) && !release_s) begin
            if (hold_cnt_r != HOLD_MAX) begin
                hold_nxt_s = hold_cnt_r + HOLD_W'(1);
            end else begin
                hold_nxt_s = hold_cnt_r;
            end
        end else begin
            hold_nxt_s = {HOLD_W{1'b0}};
        end
    end

    // Hold counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt_r <= {HOLD_W{1'b0}};
        end else begin
            hold_cnt_r <= hold_nxt_s;
        end
    end
`else
    assign force_s = 1'b0;
`endif

    // Arbitration FSM next-state and registered-output values.
    always_comb begin
        state_nxt_s = state_r;
        gnt_nxt_s   = gnt_r;
        sel_nxt_s   = sel_r;
        busy_nxt_s  = busy_r;
        ptr_nxt_s   = ptr_r;
        case (state_r)
            IDLE: begin
                if (idle_pick_s[SEL_W]) begin
                    state_nxt_s = GRANT;
                    sel_nxt_s   = idle_pick_s[SEL_W-1:0];
                    gnt_nxt_s   = idx2oh(idle_pick_s[SEL_W-1:0]);
                    busy_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GRANT: begin
                if (release_s) begin
                    ptr_nxt_s = rot_ptr_s;
                    if (rel_pick_s[SEL_W]) begin
                        state_nxt_s = GRANT;
                        sel_nxt_s   = rel_pick_s[SEL_W-1:0];
                        gnt_nxt_s   = idx2oh(rel_pick_s[SEL_W-1:0]);
                        busy_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                        gnt_nxt_s   = 4'b0000;
                        busy_nxt_s  = 1'b0;
                    end
                end else begin
                    state_nxt_s = GRANT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                gnt_nxt_s   = 4'b0000;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // Arbitration state and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            gnt_r   <= 4'b0000;
            sel_r   <= 2'd0;
            busy_r  <= 1'b0;
            ptr_r   <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            gnt_r   <= gnt_nxt_s;
            sel_r   <= sel_nxt_s;
            busy_r  <= busy_nxt_s;
            ptr_r   <= ptr_nxt_s;
        end
    end

    mux4_dp #(.DW(DW)) u_dp (
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .sel (sel_r),
        .y   (y_s)
    );

    assign gnt  = gnt_r;
    assign sel  = sel_r;
    assign busy = busy_r;
    assign out  = busy_r ? y_s : {DW{1'b0}};

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter (timeout case runs when MUX_ARB_TIMEOUT_EN is defined).
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [0:0] a, b, c, d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic [0:0] out;

    int n_vec;
    int n_err;

    mux_rr_arbiter #(.DW(1), .MAX_HOLD(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .gnt   (gnt),
        .sel   (sel),
        .busy  (busy),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    logic [3:0] rot_req  [5];
    logic [3:0] rot_gnt  [5];
    logic [3:0] np_req   [3];
    logic [3:0] np_gnt   [3];

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        req   = 4'b1111;
        a = 1'b1; b = 1'b1; c = 1'b1; d = 1'b1;

        // T1: reset with all requesting
        tick();
        tick();
        check_vec("t1_gnt",  32'(gnt),  32'h0);
        check_vec("t1_busy", 32'(busy), 32'h0);
        check_vec("t1_sel",  32'(sel),  32'h0);
        check_vec("t1_out",  32'(out),  32'h0);

        // T2: single requester c
        rst_n = 1'b1;
        req = 4'b0100;
        a = 1'b0; b = 1'b0; c = 1'b1; d = 1'b0;
        tick();
        check_vec("t2_gnt",  32'(gnt),  32'h4);
        check_vec("t2_sel",  32'(sel),  32'h2);
        check_vec("t2_busy", 32'(busy), 32'h1);
        check_vec("t2_out",  32'(out),  32'h1);
        req = 4'b0000;
        tick();
        check_vec("t2_rel_gnt",  32'(gnt),  32'h0);
        check_vec("t2_rel_busy", 32'(busy), 32'h0);
        check_vec("t2_rel_sel",  32'(sel),  32'h2);
        check_vec("t2_rel_out",  32'(out),  32'h0);

        // T3: rotation 0,1,2,3,0 with distinct lane data
        do_reset();
        a = 1'b1; b = 1'b0; c = 1'b1; d = 1'b0;
        rot_req = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
        rot_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            req = rot_req[i];
            tick();
            check_vec($sformatf("t3_gnt%0d", i),  32'(gnt),  32'(rot_gnt[i]));
            check_vec($sformatf("t3_busy%0d", i), 32'(busy), 32'h1);
            check_vec($sformatf("t3_out%0d", i),  32'(out),  32'((i % 2 == 0) ? 1 : 0));
        end

        // T4: owner 1 is not preempted; release picks from 2 onward
        np_req = '{4'b0101, 4'b1001, 4'b0001};
        np_gnt = '{4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 3; i++) begin
            do_reset();
            req = 4'b0010;
            tick();
            check_vec($sformatf("t4_own%0d", i), 32'(gnt), 32'h2);
            req = 4'b0011;
            tick();
            check_vec($sformatf("t4_hold%0d", i), 32'(gnt), 32'h2);
            req = np_req[i];
            tick();
            check_vec($sformatf("t4_next%0d", i), 32'(gnt),  32'(np_gnt[i]));
            check_vec($sformatf("t4_busy%0d", i), 32'(busy), 32'h1);
        end

`ifdef MUX_ARB_TIMEOUT_EN
        // T5: forced rotation every 3 cycles, sole requester kept
        do_reset();
        req = 4'b0011;
        for (int i = 0; i < 9; i++) begin
            tick();
            check_vec($sformatf("t5_alt%0d", i), 32'(gnt), 32'(((i / 3) % 2 == 1) ? 4'b0010 : 4'b0001));
        end
        req = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_vec($sformatf("t5_sole%0d", i), 32'(gnt), 32'h1);
        end
`endif

        // T6: reset mid-grant, pointer returns to 0
        do_reset();
        req = 4'b1000;
        tick();
        check_vec("t6_own3", 32'(gnt), 32'h8);
        rst_n = 1'b0;
        tick();
        check_vec("t6_rst_gnt",  32'(gnt),  32'h0);
        check_vec("t6_rst_busy", 32'(busy), 32'h0);
        check_vec("t6_rst_sel",  32'(sel),  32'h0);
        rst_n = 1'b1;
        req = 4'b1001;
        tick();
        check_vec("t6_after_gnt", 32'(gnt), 32'h1);
        check_vec("t6_after_out", 32'(out), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
